noc_flit_depacketizer: RTL and testbench
========================================

# noc_flit_depacketizer

Local-port receive end of the NoC packet protocol: accepts flits from a router's LOCAL output and checks the head flit's destination against this node's ID. It presents the decoded AXI header (source, type, pack order, length) as one handshake and the payload as a separate stream with last. It enforces packet framing and length, and reports violations. It sits between the router LOCAL port and the node's AXI slave-side bridge, mirroring the packetizer on the inject side.

## Interface
Parameters:
- FLIT_W, 64, flit width; bits [FLIT_W-1:FLIT_W-2] carry flit type
- DATA_W, FLIT_W-2, payload width
- ID_X_W, 2, X coordinate width
- ID_Y_W, 2, Y coordinate width
- TYPE_W, 2, AXI type field width
- ORDER_W, 8, pack-order field width
- LEN_W, 8, length field width (number of data flits minus one)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- local_x / local_y  in  ID_X_W / ID_Y_W  this node's coordinates, quasi-static
- flit_in_valid / flit_in_ready  in / out  1  flit handshake
- flit_in  in  FLIT_W  flit
- hdr_valid / hdr_ready  out / in  1  header handshake
- hdr_src_x, hdr_src_y, hdr_type, hdr_order, hdr_len  out  field widths  decoded header
- dat_valid / dat_ready  out / in  1  payload handshake
- dat  out  DATA_W  payload
- dat_last  out  1  final payload beat
- err_pulse  out  1  one-cycle error strobe
- err_code  out  2  01 dest mismatch, 10 length mismatch, 11 framing error

## Operation
- Flit types in flit_in[FLIT_W-1:FLIT_W-2]: 10 HEAD, 00 BODY, 01 TAIL, 11 reserved.
- HEAD payload, LSB first: dest_x, dest_y, src_x, src_y, type, order, len. Upper bits are ignored.
- States:
  - IDLE: flit_in_ready = !hdr_valid.
  - HDR: flit_in_ready = 0.
  - BODY: flit_in_ready = !dat_valid || dat_ready.
  - DROP: flit_in_ready = 1.
- IDLE, HEAD accepted:
  - If dest == local: latch fields, set hdr_valid, go to HDR.
  - Else: error 01, go to DROP; no header is emitted.
- IDLE, BODY/TAIL/reserved accepted: discard, error 11, stay in IDLE.
- HDR: stays until hdr_ready && hdr_valid, then goes to BODY with beat counter cnt = 0.
- BODY, BODY flit:
  - Forward payload, cnt++.
  - If cnt == len: force dat_last = 1, error 10, go to DROP.
- BODY, TAIL flit:
  - Forward payload with dat_last = 1, go to IDLE.
  - If cnt != len: error 10.
- BODY, HEAD/reserved flit: discard, error 11, stay in BODY.
- DROP: consume flits silently until TAIL is accepted, then go to IDLE.
- Counter is LEN_W+1 bits wide, so it never wraps for len = 2^LEN_W-1.

## Timing
- Reset values: state IDLE; hdr_valid, dat_valid, dat_last, err_pulse = 0; all hdr_* fields, dat, err_code = 0; flit_in_ready = 1.
- Header: hdr_valid rises the cycle after HEAD acceptance. Fields stay stable while hdr_valid && !hdr_ready.
- Payload latency: one cycle. dat, dat_last hold while dat_valid && !dat_ready.
- Throughput is 1 flit/cycle with dat_ready held high; accept and drain in the same cycle is allowed.
- A new HEAD may be accepted the cycle after TAIL, while the last beat is still pending.
- err_pulse fires for exactly one cycle, the cycle after the offending flit is accepted. err_code is valid with it and holds until the next error.
- Reset mid-packet clears everything. Orphan BODY/TAIL flits that follow produce error 11 each.

## Structure
- Add to Noc_parameters package:
  - enum e_flit_type {FLIT_BODY=2'b00, FLIT_TAIL=2'b01, FLIT_HEAD=2'b10, FLIT_RSV=2'b11}
  - enum e_rx_err {ERR_NONE, ERR_DEST, ERR_LEN, ERR_FRAME}
  - head-field offset constants
- State enum stays local.
- One sub-module: noc_pipe_reg, a one-entry valid/ready register for the dat/dat_last output.

## Test plan
- Local node (1,2): HEAD dest (1,2), src (3,0), type 1, order 5, len 2, then BODY, BODY, TAIL, all ready high → header fields match; three beats, dat_last on the third; no error.
- Same packet with dat_ready toggled every cycle → beats are held stable while stalled, no loss or duplication; flit_in_ready tracks the rule.
- HEAD dest (0,0) at node (1,2), len 1 → error 01 once; no hdr_valid or dat_valid; all flits through TAIL consumed; next HEAD is accepted normally.
- len 0 followed by BODY, BODY, TAIL → one beat with dat_last, error 10, remaining flits dropped. Separately, len 3 with BODY, TAIL → two beats, error 10 on TAIL.
- Stray TAIL in IDLE; HEAD inside BODY → error 11 each; no output beat for either.
- Assert rst_n mid-BODY, release, then feed the rest of the packet → outputs at reset values; error 11 per orphan flit; next valid packet decodes correctly.

Source files
------------

// File: rtl/noc_flit_depacketizer_pkg.sv
// Shared NoC receive-side definitions: flit types, error codes and HEAD payload layout.
package noc_flit_depacketizer_pkg;

  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_TAIL = 2'b01,
    FLIT_HEAD = 2'b10,
    FLIT_RSV  = 2'b11
  } e_flit_type;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_DEST  = 2'b01,
    ERR_LEN   = 2'b10,
    ERR_FRAME = 2'b11
  } e_rx_err;

  typedef enum logic [2:0] {
    HF_DEST_X,
    HF_DEST_Y,
    HF_SRC_X,
    HF_SRC_Y,
    HF_TYPE,
    HF_ORDER,
    HF_LEN
  } e_head_field;

  localparam int unsigned FLIT_TYPE_W = 2;

  // HEAD fields are packed LSB first in the order of e_head_field.
  function automatic int unsigned head_off(input e_head_field f,
                                           input int unsigned xw,
                                           input int unsigned yw,
                                           input int unsigned tw,
                                           input int unsigned ow);
    case (f)
      HF_DEST_X: return 0;
      HF_DEST_Y: return xw;
      HF_SRC_X:  return xw + yw;
      HF_SRC_Y:  return 2 * xw + yw;
      HF_TYPE:   return 2 * xw + 2 * yw;
      HF_ORDER:  return 2 * xw + 2 * yw + tw;
      HF_LEN:    return 2 * xw + 2 * yw + tw + ow;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/noc_pipe_reg.sv
// One-entry valid/ready register; accepts a new word whenever empty or draining.
module noc_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/noc_flit_depacketizer.sv
// Local-port NoC receiver: checks HEAD destination, emits the decoded header as one
// handshake and the payload as a stream with last, enforcing framing and length.
module noc_flit_depacketizer
  import noc_flit_depacketizer_pkg::*;
#(
  parameter int FLIT_W  = 64,
  parameter int DATA_W  = FLIT_W - 2,
  parameter int ID_X_W  = 2,
  parameter int ID_Y_W  = 2,
  parameter int TYPE_W  = 2,
  parameter int ORDER_W = 8,
  parameter int LEN_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ID_X_W-1:0]  local_x,
  input  logic [ID_Y_W-1:0]  local_y,
  input  logic               flit_in_valid,
  output logic               flit_in_ready,
  input  logic [FLIT_W-1:0]  flit_in,
  output logic               hdr_valid,
  input  logic               hdr_ready,
  output logic [ID_X_W-1:0]  hdr_src_x,
  output logic [ID_Y_W-1:0]  hdr_src_y,
  output logic [TYPE_W-1:0]  hdr_type,
  output logic [ORDER_W-1:0] hdr_order,
  output logic [LEN_W-1:0]   hdr_len,
  output logic               dat_valid,
  input  logic               dat_ready,
  output logic [DATA_W-1:0]  dat,
  output logic               dat_last,
  output logic               err_pulse,
  output logic [1:0]         err_code
);

  localparam int unsigned OFF_DX  = head_off(HF_DEST_X, ID_X_W, ID_Y_W, TYPE_W, ORDER_W);
  localparam int unsigned OFF_DY  = head_off(HF_DEST_Y, ID_X_W, ID_Y_W, TYPE_W, ORDER_W);
  localparam int unsigned OFF_SX  = head_off(HF_SRC_X,  ID_X_W, ID_Y_W, TYPE_W, ORDER_W);
  localparam int unsigned OFF_SY  = head_off(HF_SRC_Y,  ID_X_W, ID_Y_W, TYPE_W, ORDER_W);
  localparam int unsigned OFF_TY  = head_off(HF_TYPE,   ID_X_W, ID_Y_W, TYPE_W, ORDER_W);
  localparam int unsigned OFF_ORD = head_off(HF_ORDER,  ID_X_W, ID_Y_W, TYPE_W, ORDER_W);
  localparam int unsigned OFF_LEN = head_off(HF_LEN,    ID_X_W, ID_Y_W, TYPE_W, ORDER_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_BODY,
    S_DROP
  } state_e;

  state_e             state_q, state_d;
  logic               hdr_valid_q, hdr_valid_d;
  logic [ID_X_W-1:0]  src_x_q, src_x_d;
  logic [ID_Y_W-1:0]  src_y_q, src_y_d;
  logic [TYPE_W-1:0]  type_q, type_d;
  logic [ORDER_W-1:0] order_q, order_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W:0]     cnt_q, cnt_d;
  logic               err_pulse_q, err_pulse_d;
  e_rx_err            err_code_q, err_code_d;
  e_rx_err            err_now;

  e_flit_type         flit_type;
  logic               flit_acc;
  logic               dest_match;
  logic               push, push_last;
  logic               pipe_in_ready;
  logic [LEN_W:0]     len_ext;

  assign flit_type  = e_flit_type'(flit_in[FLIT_W-1 -: FLIT_TYPE_W]);
  assign flit_acc   = flit_in_valid && flit_in_ready;
  assign dest_match = (flit_in[OFF_DX +: ID_X_W] == local_x) &&
                      (flit_in[OFF_DY +: ID_Y_W] == local_y);
  // Counter is one bit wider than len so len = all-ones never wraps.
  assign len_ext    = {1'b0, len_q};

  always_comb begin
    flit_in_ready = 1'b0;
    case (state_q)
      S_IDLE:  flit_in_ready = !hdr_valid_q;
      S_HDR:   flit_in_ready = 1'b0;
      S_BODY:  flit_in_ready = pipe_in_ready;
      S_DROP:  flit_in_ready = 1'b1;
      default: flit_in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    hdr_valid_d = hdr_valid_q;
    src_x_d     = src_x_q;
    src_y_d     = src_y_q;
    type_d      = type_q;
    order_d     = order_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_now     = ERR_NONE;
    push        = 1'b0;
    push_last   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flit_acc) begin
          if (flit_type == FLIT_HEAD) begin
            if (dest_match) begin
              src_x_d     = flit_in[OFF_SX  +: ID_X_W];
              src_y_d     = flit_in[OFF_SY  +: ID_Y_W];
              type_d      = flit_in[OFF_TY  +: TYPE_W];
              order_d     = flit_in[OFF_ORD +: ORDER_W];
              len_d       = flit_in[OFF_LEN +: LEN_W];
              hdr_valid_d = 1'b1;
              state_d     = S_HDR;
            end else begin
              err_now = ERR_DEST;
              state_d = S_DROP;
            end
          end else begin
            err_now = ERR_FRAME;
          end
        end
      end

      S_HDR: begin
        if (hdr_valid_q && hdr_ready) begin
          hdr_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_BODY;
        end
      end

      S_BODY: begin
        if (flit_acc) begin
          case (flit_type)
            FLIT_BODY: begin
              push  = 1'b1;
              cnt_d = cnt_q + 1'b1;
              // Packet overran its declared length: close it here, drop the rest.
              if (cnt_q == len_ext) begin
                push_last = 1'b1;
                err_now   = ERR_LEN;
                state_d   = S_DROP;
              end
            end
            FLIT_TAIL: begin
              push      = 1'b1;
              push_last = 1'b1;
              state_d   = S_IDLE;
              if (cnt_q != len_ext) err_now = ERR_LEN;
            end
            default: err_now = ERR_FRAME;
          endcase
        end
      end

      S_DROP: begin
        if (flit_acc && flit_type == FLIT_TAIL) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    err_pulse_d = (err_now != ERR_NONE);
    err_code_d  = (err_now != ERR_NONE) ? err_now : err_code_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hdr_valid_q <= 1'b0;
      src_x_q     <= '0;
      src_y_q     <= '0;
      type_q      <= '0;
      order_q     <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      hdr_valid_q <= hdr_valid_d;
      src_x_q     <= src_x_d;
      src_y_q     <= src_y_d;
      type_q      <= type_d;
      order_q     <= order_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  noc_pipe_reg #(
    .W (DATA_W + 1)
  ) u_dat_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (push),
    .in_ready_o  (pipe_in_ready),
    .in_data_i   ({push_last, flit_in[DATA_W-1:0]}),
    .out_valid_o (dat_valid),
    .out_ready_i (dat_ready),
    .out_data_o  ({dat_last, dat})
  );

  assign hdr_valid = hdr_valid_q;
  assign hdr_src_x = src_x_q;
  assign hdr_src_y = src_y_q;
  assign hdr_type  = type_q;
  assign hdr_order = order_q;
  assign hdr_len   = len_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_noc_flit_depacketizer.sv
// Directed bench for noc_flit_depacketizer at node (1,2).
module tb_noc_flit_depacketizer;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_HEAD = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  local_x = 2'd1;
  logic [1:0]  local_y = 2'd2;
  logic        flit_in_valid = 1'b0;
  logic        flit_in_ready;
  logic [63:0] flit_in = '0;
  logic        hdr_valid;
  logic        hdr_ready = 1'b1;
  logic [1:0]  hdr_src_x, hdr_src_y, hdr_type;
  logic [7:0]  hdr_order, hdr_len;
  logic        dat_valid;
  logic        dat_ready = 1'b1;
  logic [61:0] dat;
  logic        dat_last;
  logic        err_pulse;
  logic [1:0]  err_code;

  int checks = 0;
  int fails  = 0;

  logic [63:0] beat_q[$];
  int          err_cnt = 0;
  logic [1:0]  last_err = '0;
  int          hdr_seen = 0;
  int          hdr_cnt = 0;
  int          stall_bad = 0;
  int          rdy_bad = 0;
  logic        prev_stall = 1'b0;
  logic [61:0] prev_dat = '0;
  logic        prev_last = 1'b0;
  logic        chk_rdy = 1'b0;
  logic        tog = 1'b0;

  noc_flit_depacketizer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .local_x       (local_x),
    .local_y       (local_y),
    .flit_in_valid (flit_in_valid),
    .flit_in_ready (flit_in_ready),
    .flit_in       (flit_in),
    .hdr_valid     (hdr_valid),
    .hdr_ready     (hdr_ready),
    .hdr_src_x     (hdr_src_x),
    .hdr_src_y     (hdr_src_y),
    .hdr_type      (hdr_type),
    .hdr_order     (hdr_order),
    .hdr_len       (hdr_len),
    .dat_valid     (dat_valid),
    .dat_ready     (dat_ready),
    .dat           (dat),
    .dat_last      (dat_last),
    .err_pulse     (err_pulse),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tog) dat_ready = ~dat_ready;

  // Samples between the input drive (negedge) and the next active edge.
  always @(negedge clk) begin
    #2;
    if (dat_valid && dat_ready) beat_q.push_back({1'b0, dat_last, dat});
    if (err_pulse) begin
      err_cnt++;
      last_err = err_code;
    end
    if (hdr_valid) hdr_seen++;
    if (hdr_valid && hdr_ready) hdr_cnt++;
    if (prev_stall && (!dat_valid || dat !== prev_dat || dat_last !== prev_last)) stall_bad++;
    prev_stall = dat_valid && !dat_ready;
    prev_dat   = dat;
    prev_last  = dat_last;
    if (chk_rdy && (flit_in_ready !== (!dat_valid || dat_ready))) rdy_bad++;
  end

  function automatic logic [61:0] mk_head(input logic [1:0] dx, input logic [1:0] dy,
                                          input logic [1:0] sx, input logic [1:0] sy,
                                          input logic [1:0] ty, input logic [7:0] ord,
                                          input logic [7:0] len);
    logic [61:0] p;
    p = {36'hA5A5A5A5A, 26'h0};
    p[1:0]   = dx;
    p[3:2]   = dy;
    p[5:4]   = sx;
    p[7:6]   = sy;
    p[9:8]   = ty;
    p[17:10] = ord;
    p[25:18] = len;
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input logic last,
                            input logic [61:0] data);
    logic [63:0] obs;
    obs = (idx < beat_q.size()) ? beat_q[idx] : 64'hFFFF_FFFF_FFFF_FFFF;
    check(tag, obs, {1'b0, last, data});
  endtask

  task automatic clr();
    beat_q.delete();
    err_cnt   = 0;
    last_err  = '0;
    hdr_seen  = 0;
    hdr_cnt   = 0;
    stall_bad = 0;
    rdy_bad   = 0;
  endtask

  task automatic send(input logic [1:0] t, input logic [61:0] p);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    @(negedge clk);
    flit_in_valid = 1'b1;
    flit_in       = {t, p};
    while (!acc) begin
      #1;
      acc = flit_in_ready;
      @(posedge clk);
      if (!acc) begin
        n++;
        if (n > 100) begin
          checks++;
          fails++;
          $error("FAIL send_timeout: flit %0h observed not accepted expected accepted", {t, p});
          flit_in_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    flit_in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed simulation still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_dat_valid", dat_valid, 0);
    check("rst_dat_last", dat_last, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_hdr_fields", {hdr_src_x, hdr_src_y, hdr_type, hdr_order, hdr_len}, 0);
    check("rst_dat", dat, 0);
    check("rst_err_code", err_code, 0);
    check("rst_flit_ready", flit_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    clr();

    // Nominal packet, all ready high
    send(T_HEAD, mk_head(2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 8'd5, 8'd2));
    send(T_BODY, 62'h111);
    send(T_BODY, 62'h222);
    send(T_TAIL, 62'h333);
    idle(4);
    check("t1_hdr_cnt", hdr_cnt, 1);
    check("t1_src_x", hdr_src_x, 3);
    check("t1_src_y", hdr_src_y, 0);
    check("t1_type", hdr_type, 1);
    check("t1_order", hdr_order, 5);
    check("t1_len", hdr_len, 2);
    check("t1_nbeats", beat_q.size(), 3);
    check_beat("t1_beat0", 0, 1'b0, 62'h111);
    check_beat("t1_beat1", 1, 1'b0, 62'h222);
    check_beat("t1_beat2", 2, 1'b1, 62'h333);
    check("t1_err_cnt", err_cnt, 0);

    // Header held under backpressure, then payload with toggling dat_ready
    clr();
    hdr_ready = 1'b0;
    send(T_HEAD, mk_head(2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 8'd5, 8'd2));
    idle(3);
    check("t2_hdr_held", hdr_valid, 1);
    check("t2_hdr_order_held", hdr_order, 5);
    check("t2_ready_in_hdr", flit_in_ready, 0);
    hdr_ready = 1'b1;
    tog = 1'b1;
    send(T_BODY, 62'h1A1);
    chk_rdy = 1'b1;
    send(T_BODY, 62'h1A2);
    send(T_TAIL, 62'h1A3);
    chk_rdy = 1'b0;
    idle(8);
    tog = 1'b0;
    dat_ready = 1'b1;
    idle(3);
    check("t2_hdr_cnt", hdr_cnt, 1);
    check("t2_nbeats", beat_q.size(), 3);
    check_beat("t2_beat0", 0, 1'b0, 62'h1A1);
    check_beat("t2_beat1", 1, 1'b0, 62'h1A2);
    check_beat("t2_beat2", 2, 1'b1, 62'h1A3);
    check("t2_stall_stable", stall_bad, 0);
    check("t2_ready_rule", rdy_bad, 0);
    check("t2_err_cnt", err_cnt, 0);

    // Destination mismatch, then a normal single-beat packet
    clr();
    send(T_HEAD, mk_head(2'd0, 2'd0, 2'd3, 2'd3, 2'd2, 8'd9, 8'd1));
    send(T_BODY, 62'h0D1);
    send(T_TAIL, 62'h0D2);
    idle(3);
    check("t3_err_cnt", err_cnt, 1);
    check("t3_err_code", last_err, 2'b01);
    check("t3_no_hdr", hdr_seen, 0);
    check("t3_no_beats", beat_q.size(), 0);
    clr();
    send(T_HEAD, mk_head(2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 8'd7, 8'd0));
    send(T_TAIL, 62'hABC);
    idle(3);
    check("t3b_hdr_cnt", hdr_cnt, 1);
    check("t3b_nbeats", beat_q.size(), 1);
    check_beat("t3b_beat0", 0, 1'b1, 62'hABC);
    check("t3b_err_cnt", err_cnt, 0);

    // Overlong packet: len 0 with BODY, BODY, TAIL
    clr();
    send(T_HEAD, mk_head(2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 8'd1, 8'd0));
    send(T_BODY, 62'h11);
    send(T_BODY, 62'h22);
    send(T_TAIL, 62'h33);
    idle(3);
    check("t4a_nbeats", beat_q.size(), 1);
    check_beat("t4a_beat0", 0, 1'b1, 62'h11);
    check("t4a_err_cnt", err_cnt, 1);
    check("t4a_err_code", last_err, 2'b10);

    // Short packet: len 3 with BODY, TAIL
    clr();
    send(T_HEAD, mk_head(2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 8'd2, 8'd3));
    send(T_BODY, 62'h44);
    send(T_TAIL, 62'h55);
    idle(3);
    check("t4b_nbeats", beat_q.size(), 2);
    check_beat("t4b_beat0", 0, 1'b0, 62'h44);
    check_beat("t4b_beat1", 1, 1'b1, 62'h55);
    check("t4b_err_cnt", err_cnt, 1);
    check("t4b_err_code", last_err, 2'b10);

    // Stray TAIL in IDLE
    clr();
    send(T_TAIL, 62'h5);
    idle(3);
    check("t5a_err_cnt", err_cnt, 1);
    check("t5a_err_code", last_err, 2'b11);
    check("t5a_no_beats", beat_q.size(), 0);
    check("t5a_no_hdr", hdr_seen, 0);

    // HEAD inside BODY is discarded
    clr();
    send(T_HEAD, mk_head(2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 8'd3, 8'd1));
    send(T_BODY, 62'h66);
    send(T_HEAD, mk_head(2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 8'hFF, 8'd0));
    send(T_TAIL, 62'h77);
    idle(3);
    check("t5b_nbeats", beat_q.size(), 2);
    check_beat("t5b_beat0", 0, 1'b0, 62'h66);
    check_beat("t5b_beat1", 1, 1'b1, 62'h77);
    check("t5b_err_cnt", err_cnt, 1);
    check("t5b_err_code", last_err, 2'b11);
    check("t5b_hdr_cnt", hdr_cnt, 1);

    // Reset mid-BODY, orphans, then a clean packet
    clr();
    send(T_HEAD, mk_head(2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 8'd5, 8'd2));
    send(T_BODY, 62'h88);
    idle(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_hdr_valid", hdr_valid, 0);
    check("t6_rst_dat_valid", dat_valid, 0);
    check("t6_rst_dat", {dat_last, dat}, 0);
    check("t6_rst_hdr_fields", {hdr_src_x, hdr_src_y, hdr_type, hdr_order, hdr_len}, 0);
    check("t6_rst_err_code", err_code, 0);
    check("t6_rst_ready", flit_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    send(T_BODY, 62'h99);
    send(T_TAIL, 62'hAA);
    idle(3);
    check("t6_orphan_errs", err_cnt, 2);
    check("t6_orphan_code", last_err, 2'b11);
    check("t6_orphan_beats", beat_q.size(), 0);
    check("t6_orphan_hdr", hdr_seen, 0);
    clr();
    send(T_HEAD, mk_head(2'd1, 2'd2, 2'd2, 2'd1, 2'd3, 8'hA5, 8'd1));
    send(T_BODY, 62'hBB);
    send(T_TAIL, 62'hCC);
    idle(3);
    check("t6_hdr_cnt", hdr_cnt, 1);
    check("t6_hdr_fields", {hdr_src_x, hdr_src_y, hdr_type, hdr_order, hdr_len},
          {2'd2, 2'd1, 2'd3, 8'hA5, 8'd1});
    check("t6_nbeats", beat_q.size(), 2);
    check_beat("t6_beat0", 0, 1'b0, 62'hBB);
    check_beat("t6_beat1", 1, 1'b1, 62'hCC);
    check("t6_err_cnt", err_cnt, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
